serial_adder: RTL and testbench

Parametrised bit-serial adder/subtractor. Each operation uses one full-adder cell and a carry flip-flop, one bit per clock, LSB first, to add or subtract two WIDTH-bit operands. A start/busy/done handshake brackets each operation. It trades latency for area where a WIDTH-bit parallel adder is too large, and it adds carry-in, subtract mode and signed-overflow detection.

---
 rtl/serial_adder_pkg.sv | 13 +
 rtl/serial_adder_if.sv | 25 ++
 rtl/serial_adder_fa_cell.sv | 18 +
 rtl/serial_adder.sv | 95 +++++++++
 tb/tb_serial_adder.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder/subtractor.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/serial_adder_if.sv
// Operand/result bus of the serial adder with its start/busy/done handshake.
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             overflow;
  logic             busy;
  logic             done;

  modport master (
    output start, sub, a, b, cin,
    input  sum, cout, overflow, busy, done
  );

  modport slave (
    input  start, sub, a, b, cin,
    output sum, cout, overflow, busy, done
  );
endinterface

// File: rtl/serial_adder_fa_cell.sv
// Gate-level one-bit full adder: the only arithmetic cell of the serial adder.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic s,
  output logic ca
);
  logic ab_x;
  logic ab_a;
  logic c_a;

  xor g_x0 (ab_x, a, b);
  xor g_x1 (s, ab_x, c);
  and g_a0 (ab_a, a, b);
  and g_a1 (c_a, ab_x, c);
  or  g_o0 (ca, ab_a, c_a);
endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one full-adder cell plus a carry FF, one bit
// per clock, LSB first. Subtraction is a + ~b + 1.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input logic           clk,
  input logic           rst,
  serial_adder_if.slave bus
);
  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] sum_r;
  logic [CNT_W-1:0] cnt;
  logic             carry_r;
  logic             cout_r;
  logic             ovf_r;
  logic             fa_s;
  logic             fa_ca;
  logic             accept;
  logic             last_bit;

  fa_cell u_fa (
    .a  (a_sr[0]),
    .b  (b_sr[0]),
    .c  (carry_r),
    .s  (fa_s),
    .ca (fa_ca)
  );

  assign accept   = bus.start && ((state == IDLE) || (state == DONE));
  assign last_bit = (cnt == CNT_LAST);

  // Next-state logic: start is only honoured outside RUN.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (bus.start) state_nxt = RUN;
      RUN:     if (last_bit)  state_nxt = DONE;
      DONE:    state_nxt = bus.start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Operand load on accepted start, then one bit per RUN cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sr    <= '0;
      b_sr    <= '0;
      sum_r   <= '0;
      cnt     <= '0;
      carry_r <= 1'b0;
      cout_r  <= 1'b0;
      ovf_r   <= 1'b0;
    end else if (accept) begin
      a_sr    <= bus.a;
      b_sr    <= (bus.sub == MODE_SUB) ? ~bus.b : bus.b;
      carry_r <= (bus.sub == MODE_SUB) ? 1'b1 : bus.cin;
      sum_r   <= '0;
      cnt     <= '0;
      cout_r  <= 1'b0;
      ovf_r   <= 1'b0;
    end else if (state == RUN) begin
      a_sr    <= {1'b0, a_sr[WIDTH-1:1]};
      b_sr    <= {1'b0, b_sr[WIDTH-1:1]};
      sum_r   <= {fa_s, sum_r[WIDTH-1:1]};
      carry_r <= fa_ca;
      cnt     <= cnt + CNT_W'(1);
      if (last_bit) begin
        cout_r <= fa_ca;
        // Signed overflow: carry into the MSB differs from carry out of it.
        ovf_r  <= carry_r ^ fa_ca;
      end
    end
  end

  assign bus.sum      = sum_r;
  assign bus.cout     = cout_r;
  assign bus.overflow = ovf_r;
  assign bus.busy     = (state == RUN);
  assign bus.done     = (state == DONE);

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: 8-bit directed vectors and protocol cases,
// then an exhaustive sweep of a 4-bit instance against a behavioural model.
module tb_serial_adder;

  typedef struct {
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
    int         cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   passed = 0;
  int   dones8 = 0;
  int   dones4 = 0;
  exp_t q8[$];
  exp_t q4[$];

  serial_adder_if #(.WIDTH(8)) bus8 ();
  serial_adder_if #(.WIDTH(4)) bus4 ();

  serial_adder #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
  serial_adder #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor for the 8-bit instance: pop one expectation per done pulse.
  always @(negedge clk) begin
    if (bus8.done) begin
      exp_t e;
      dones8++;
      check("busy_with_done8", {31'd0, bus8.busy}, 32'd0);
      if (q8.size() == 0) begin
        total++;
        $display("FAIL unexpected_done8: done seen at cycle %0d, expected none", cyc);
      end else begin
        e = q8.pop_front();
        check("sum8", {24'd0, bus8.sum}, {24'd0, e.sum});
        check("cout8", {31'd0, bus8.cout}, {31'd0, e.cout});
        check("ovf8", {31'd0, bus8.overflow}, {31'd0, e.ovf});
        check("latency8", cyc, e.cyc);
      end
    end
  end

  // Monitor for the 4-bit instance.
  always @(negedge clk) begin
    if (bus4.done) begin
      exp_t e;
      dones4++;
      if (q4.size() == 0) begin
        total++;
        $display("FAIL unexpected_done4: done seen at cycle %0d, expected none", cyc);
      end else begin
        e = q4.pop_front();
        check("sum4", {28'd0, bus4.sum}, {24'd0, e.sum});
        check("cout4", {31'd0, bus4.cout}, {31'd0, e.cout});
        check("ovf4", {31'd0, bus4.overflow}, {31'd0, e.ovf});
        check("latency4", cyc, e.cyc);
      end
    end
  end

  task automatic wait_q8(input int budget);
    int n = 0;
    while (q8.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (q8.size() != 0) begin
      total++;
      $display("FAIL timeout8: %0d results outstanding after %0d cycles, expected 0", q8.size(), budget);
      q8.delete();
    end
  endtask

  task automatic wait_q4(input int budget);
    int n = 0;
    while (q4.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (q4.size() != 0) begin
      total++;
      $display("FAIL timeout4: %0d results outstanding after %0d cycles, expected 0", q4.size(), budget);
      q4.delete();
    end
  endtask

  // One 8-bit operation with a hand-computed result; done due 9 cycles later.
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic cin, input logic sub,
                     input logic [7:0] es, input logic ec, input logic eo);
    @(negedge clk);
    bus8.a = a; bus8.b = b; bus8.cin = cin; bus8.sub = sub; bus8.start = 1'b1;
    q8.push_back('{es, ec, eo, cyc + 9});
    @(negedge clk);
    bus8.start = 1'b0;
    wait_q8(20);
  endtask

  initial begin
    int d0;
    int n0;
    logic [4:0] full;
    logic [3:0] bb;
    logic [3:0] s4;

    bus8.start = 1'b0; bus8.sub = 1'b0; bus8.a = '0; bus8.b = '0; bus8.cin = 1'b0;
    bus4.start = 1'b0; bus4.sub = 1'b0; bus4.a = '0; bus4.b = '0; bus4.cin = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_sum", {24'd0, bus8.sum}, 32'd0);
    check("rst_cout", {31'd0, bus8.cout}, 32'd0);
    check("rst_ovf", {31'd0, bus8.overflow}, 32'd0);
    check("rst_busy", {31'd0, bus8.busy}, 32'd0);
    check("rst_done", {31'd0, bus8.done}, 32'd0);
    rst = 1'b0;

    // Directed arithmetic vectors
    op8(8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0, 1'b1);
    op8(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    op8(8'h7F, 8'h00, 1'b1, 1'b0, 8'h80, 1'b0, 1'b1);
    op8(8'h10, 8'h20, 1'b1, 1'b1, 8'hF0, 1'b0, 1'b0);
    op8(8'h20, 8'h10, 1'b0, 1'b1, 8'h10, 1'b1, 1'b0);

    // start pulsed mid-RUN with new operands is ignored
    @(negedge clk);
    bus8.a = 8'h12; bus8.b = 8'h34; bus8.cin = 1'b0; bus8.sub = 1'b0; bus8.start = 1'b1;
    q8.push_back('{8'h46, 1'b0, 1'b0, cyc + 9});
    @(negedge clk);
    bus8.start = 1'b0;
    repeat (3) @(negedge clk);
    check("busy_midrun", {31'd0, bus8.busy}, 32'd1);
    bus8.a = 8'hFF; bus8.b = 8'hFF; bus8.cin = 1'b1; bus8.sub = 1'b1; bus8.start = 1'b1;
    @(negedge clk);
    bus8.start = 1'b0;
    wait_q8(20);

    // start held through DONE: back-to-back, second done 9 cycles after first
    @(negedge clk);
    bus8.a = 8'h80; bus8.b = 8'h80; bus8.cin = 1'b0; bus8.sub = 1'b0; bus8.start = 1'b1;
    n0 = cyc;
    q8.push_back('{8'h00, 1'b1, 1'b1, n0 + 9});
    repeat (9) @(negedge clk);
    bus8.a = 8'h80; bus8.b = 8'h01; bus8.sub = 1'b1;
    q8.push_back('{8'h7F, 1'b1, 1'b1, n0 + 18});
    @(negedge clk);
    bus8.start = 1'b0;
    wait_q8(20);

    // rst at bit 4 aborts: outputs clear, no done pulse
    @(negedge clk);
    bus8.a = 8'h55; bus8.b = 8'h55; bus8.cin = 1'b0; bus8.sub = 1'b0; bus8.start = 1'b1;
    @(negedge clk);
    bus8.start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_sum", {24'd0, bus8.sum}, 32'd0);
    check("abort_cout", {31'd0, bus8.cout}, 32'd0);
    check("abort_ovf", {31'd0, bus8.overflow}, 32'd0);
    check("abort_busy", {31'd0, bus8.busy}, 32'd0);
    d0 = dones8;
    repeat (15) @(negedge clk);
    check("abort_no_done", dones8, d0);
    op8(8'h01, 8'h02, 1'b1, 1'b0, 8'h04, 1'b0, 1'b0);

    // Exhaustive 4-bit sweep against the behavioural model
    for (int sb = 0; sb < 2; sb++) begin
      for (int ci = 0; ci < 2; ci++) begin
        for (int ai = 0; ai < 16; ai++) begin
          for (int bi = 0; bi < 16; bi++) begin
            bb = (sb != 0) ? ~4'(bi) : 4'(bi);
            if (sb != 0) full = 5'(ai) + 5'(bb) + 5'd1;
            else         full = 5'(ai) + 5'(bi) + 5'(ci);
            s4 = full[3:0];
            @(negedge clk);
            bus4.a = 4'(ai); bus4.b = 4'(bi); bus4.cin = ci[0]; bus4.sub = sb[0];
            bus4.start = 1'b1;
            q4.push_back('{{4'd0, s4}, full[4],
                           (4'(ai) >> 3 == bb >> 3) && (s4[3] != 4'(ai) >> 3 ? 1'b1 : 1'b0),
                           cyc + 5});
            @(negedge clk);
            bus4.start = 1'b0;
            wait_q4(12);
          end
        end
      end
    end

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
